aes_round_scheduler: RTL and testbench
======================================

# aes_round_scheduler

Top-level sequencer for the AES-128 encryption core. It drives `keyExpansion` one round at a time and hands each fresh round key to the round datapath. It also owns the select line of the shared key SRAM, so the expansion unit and the round datapath never access it in the same cycle. It sits between the host-side control interface (`start`/`done`) and the two datapath blocks.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: index of the final AES round; rounds run 0..NUM_ROUNDS.
- `TIMEOUT_CYCLES`, default 64: watchdog limit per wait state. Used only with `AES_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins one block encryption; sampled only in IDLE and ERR.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `done`  out  1  one-cycle pulse when the block is complete.
- `error`  out  1  high while in ERR.
- `kx_enable`  out  1  one-cycle request to `keyExpansion`.
- `kx_round`  out  4  round number presented to `keyExpansion` (r+1). Held stable from KX_REQ through KX_WAIT.
- `kx_done`  in  1  `expansionDone` from `keyExpansion`.
- `rnd_start`  out  1  one-cycle request to the round datapath.
- `rnd_num`  out  4  current round r. Held stable from RND_REQ through RND_WAIT.
- `rnd_initial`  out  1  r==0: AddRoundKey only.
- `rnd_final`  out  1  r==NUM_ROUNDS: no MixColumns.
- `rnd_done`  in  1  round datapath completion.
- `sram_sel`  out  1  key SRAM owner: 0 = `keyExpansion`, 1 = round datapath.

## Operation
- States: IDLE, KX_REQ, KX_WAIT, RND_REQ, RND_WAIT, DONE, ERR. Moore outputs, all registered.
- Round counter r is 4 bits. It clears on entry to KX_REQ from IDLE or ERR, and increments on RND_WAIT→KX_REQ.
- IDLE: `start`=1 → KX_REQ.
- KX_REQ: `kx_enable`=1, `kx_round`=r+1. Round 1 means "store cipher key unchanged". Unconditionally → KX_WAIT.
- KX_WAIT: `kx_done`=1 → RND_REQ.
- RND_REQ: `rnd_start`=1, `sram_sel`=1. Unconditionally → RND_WAIT.
- RND_WAIT: `sram_sel`=1. On `rnd_done`=1: if r==NUM_ROUNDS → DONE; otherwise r←r+1 → KX_REQ.
- DONE: `done`=1 for one cycle → IDLE.
- `kx_done` and `rnd_done` are sampled only in their own WAIT state and ignored elsewhere. A completion asserted during a REQ cycle is lost; requesters must complete no earlier than the cycle after the request.
- `start` is ignored while busy.
- `sram_sel` is 0 in all states except RND_REQ and RND_WAIT. It changes only on a state transition, so ownership never changes mid-access.
- Reset values (asynchronous, immediate, including mid-block): state=IDLE, r=0, and every output 0. After reset no pending request survives; the host must reissue `start`.

## Timing
- `start` high in cycle 0 → KX_REQ in cycle 1.
- With zero-latency responders (done high in the first WAIT cycle), round r occupies cycles 4r+1..4r+4.
- Minimum latency for NUM_ROUNDS=10: `done` in cycle 45.
- Each additional waiting cycle in KX_WAIT or RND_WAIT adds exactly one cycle.
- Back-to-back blocks: `start` may be high in the cycle after `done`. The earliest next KX_REQ is two cycles after DONE.

## Configuration
- `AES_SCHED_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to KX_WAIT or RND_WAIT and increments every cycle in that state.
  - When the count reaches TIMEOUT_CYCLES without the matching done → ERR.
  - In ERR: `error`=1, `busy`=0, `sram_sel`=0. `start` → KX_REQ with r=0.
- Undefined:
  - No counter. WAIT states wait indefinitely, ERR is unreachable, and `error` is tied 0.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum `sched_state_t`;
  - `AES128_ROUNDS`=10;
  - the round-number width (4);
  - SRAM owner constants `SRAM_KX`=0 and `SRAM_RND`=1.
- One sub-module, `aes_sched_watchdog`, instantiated only under the macro. It has clear and enable inputs and an `expired` output.

## Test plan
- Reset, then `start` pulse with responders returning done on the first WAIT cycle → `done` in cycle 45. Across the block, `kx_round` sequence is 1..11, `rnd_num` sequence is 0..10, `rnd_initial` is high only in round 0, and `rnd_final` is high only in round 10.
- `kx_done` delayed 5 cycles each round → `done` in cycle 45+55=100. `sram_sel`=0 throughout every KX_WAIT.
- `start` held high through an entire block → exactly one `done`, then a second block starts two cycles later.
- Assert `rst` during RND_WAIT of round 4 → all outputs 0 in the same cycle. The following `start` begins at `kx_round`=1.
- Spurious `rnd_done` during KX_WAIT and spurious `kx_done` during RND_WAIT → ignored; the sequence and cycle count are unchanged.
- With the macro defined and TIMEOUT_CYCLES=8, withhold `kx_done` in round 2 → `error`=1 after 8 KX_WAIT cycles. A subsequent `start` clears `error` and restarts at r=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round scheduler and its helpers.
//
// Contents:
//   sched_state_t   scheduler FSM states
//   AES128_ROUNDS   index of the final AES-128 round
//   ROUND_W         width of round numbers on the datapath interfaces
//   SRAM_KX/RND     key SRAM owner encodings for sram_sel
//   is_busy_state   states in which a block encryption is in progress
package aes_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int ROUND_W       = 4;

    localparam logic SRAM_KX  = 1'b0;
    localparam logic SRAM_RND = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KX_REQ,
        S_KX_WAIT,
        S_RND_REQ,
        S_RND_WAIT,
        S_DONE,
        S_ERR
    } sched_state_t;

    function automatic logic is_busy_state(input sched_state_t s);
        return !(s inside {S_IDLE, S_DONE, S_ERR});
    endfunction

endpackage

// File: rtl/aes_sched_watchdog.sv
// Per-wait-state watchdog for the AES round scheduler.
//
// Only compiled when AES_SCHED_TIMEOUT_EN is defined; the scheduler has no
// watchdog at all otherwise.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   clear    in   restart the count (asserted on the edge entering a wait state)
//   enable   in   high while the scheduler sits in a wait state
//   expired  out  high in the LIMIT-th consecutive enabled cycle
`ifdef AES_SCHED_TIMEOUT_EN
module aes_sched_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // The count is 0 in the first wait cycle, so the LIMIT-th cycle sees
    // LIMIT-1; the scheduler leaves for ERR on the edge that ends it.
    assign expired = enable && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/aes_round_scheduler.sv
// Top-level sequencer for the AES-128 encryption core.
//
// Steps keyExpansion one round at a time, hands each round key to the round
// datapath, and owns the key SRAM select so the two never share a cycle.
// All outputs are registered Moore decodes of the next state.
//
// Optional feature macro: AES_SCHED_TIMEOUT_EN
//   defined   -> watchdog per wait state, timeout goes to ERR
//   undefined -> wait states wait forever, error tied low
//
// Parameters:
//   NUM_ROUNDS      index of the final round (rounds 0..NUM_ROUNDS)
//   TIMEOUT_CYCLES  wait-state limit, only used with the watchdog
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a block (sampled in IDLE and ERR only)
//   busy          block in progress
//   done          one-cycle completion pulse
//   error         in ERR (watchdog build only)
//   kx_enable     one-cycle request to keyExpansion
//   kx_round      round number for keyExpansion (r+1)
//   kx_done       keyExpansion completion
//   rnd_start     one-cycle request to the round datapath
//   rnd_num       current round r
//   rnd_initial   r == 0
//   rnd_final     r == NUM_ROUNDS
//   rnd_done      round datapath completion
//   sram_sel      key SRAM owner (SRAM_KX / SRAM_RND)
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | waiting for start
// KX_REQ     | pulse kx_enable for round r+1
// KX_WAIT    | waiting for kx_done
// RND_REQ    | pulse rnd_start, SRAM handed to round datapath
// RND_WAIT   | waiting for rnd_done, SRAM owned by round datapath
// DONE       | one-cycle done pulse
// ERR        | watchdog expired, waiting for a fresh start
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES128_ROUNDS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               kx_enable,
    output logic [ROUND_W-1:0] kx_round,
    input  logic               kx_done,
    output logic               rnd_start,
    output logic [ROUND_W-1:0] rnd_num,
    output logic               rnd_initial,
    output logic               rnd_final,
    input  logic               rnd_done,
    output logic               sram_sel
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    sched_state_t       state_q, state_d;
    logic [ROUND_W-1:0] r_q, r_d;

    logic               busy_d;
    logic               done_d;
    logic               error_d;
    logic               kx_enable_d;
    logic [ROUND_W-1:0] kx_round_d;
    logic               rnd_start_d;
    logic [ROUND_W-1:0] rnd_num_d;
    logic               rnd_initial_d;
    logic               rnd_final_d;
    logic               sram_sel_d;

    logic               wd_expired;

`ifdef AES_SCHED_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // Restart on the edge that enters a wait state; the WAIT states are
    // never directly adjacent, so any entry is a change of state.
    assign wd_clear  = (state_d inside {S_KX_WAIT, S_RND_WAIT}) && (state_d != state_q);
    assign wd_enable = state_q inside {S_KX_WAIT, S_RND_WAIT};

    aes_sched_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;

    // TIMEOUT_CYCLES stays on the interface so both builds share one
    // instantiation; without the watchdog it has nothing to size.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KX_REQ;
                    r_d     = '0;
                end
            end
            S_KX_REQ: begin
                state_d = S_KX_WAIT;
            end
            S_KX_WAIT: begin
                if (kx_done) begin
                    state_d = S_RND_REQ;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            S_RND_REQ: begin
                state_d = S_RND_WAIT;
            end
            S_RND_WAIT: begin
                if (rnd_done) begin
                    if (r_q == LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_KX_REQ;
                        r_d     = r_q + ROUND_W'(1);
                    end
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_KX_REQ;
                    r_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered below,
        // so they change exactly on the state transition.
        busy_d        = is_busy_state(state_d);
        done_d        = (state_d == S_DONE);
        kx_enable_d   = (state_d == S_KX_REQ);
        rnd_start_d   = (state_d == S_RND_REQ);
        kx_round_d    = busy_d ? (r_d + ROUND_W'(1)) : '0;
        rnd_num_d     = busy_d ? r_d : '0;
        rnd_initial_d = busy_d && (r_d == '0);
        rnd_final_d   = busy_d && (r_d == LAST_ROUND);
        sram_sel_d    = (state_d inside {S_RND_REQ, S_RND_WAIT}) ? SRAM_RND : SRAM_KX;
`ifdef AES_SCHED_TIMEOUT_EN
        error_d       = (state_d == S_ERR);
`else
        error_d       = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            kx_enable   <= 1'b0;
            kx_round    <= '0;
            rnd_start   <= 1'b0;
            rnd_num     <= '0;
            rnd_initial <= 1'b0;
            rnd_final   <= 1'b0;
            sram_sel    <= SRAM_KX;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            kx_enable   <= kx_enable_d;
            kx_round    <= kx_round_d;
            rnd_start   <= rnd_start_d;
            rnd_num     <= rnd_num_d;
            rnd_initial <= rnd_initial_d;
            rnd_final   <= rnd_final_d;
            sram_sel    <= sram_sel_d;
        end
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench for aes_round_scheduler.
module tb_aes_round_scheduler;

    localparam int NR = 10;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error, kx_enable, rnd_start, rnd_initial, rnd_final, sram_sel;
    logic [3:0] kx_round, rnd_num;
    logic       kx_done, rnd_done;
    logic       kx_done_resp = 1'b0, kx_done_spur = 1'b0;
    logic       rnd_done_resp = 1'b0, rnd_done_spur = 1'b0;
    logic [15:0] outs;

    assign kx_done  = kx_done_resp | kx_done_spur;
    assign rnd_done = rnd_done_resp | rnd_done_spur;
    assign outs = {busy, done, error, kx_enable, kx_round, rnd_start, rnd_num,
                   rnd_initial, rnd_final, sram_sel};

    aes_round_scheduler #(
        .NUM_ROUNDS     (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .kx_enable   (kx_enable),
        .kx_round    (kx_round),
        .kx_done     (kx_done),
        .rnd_start   (rnd_start),
        .rnd_num     (rnd_num),
        .rnd_initial (rnd_initial),
        .rnd_final   (rnd_final),
        .rnd_done    (rnd_done),
        .sram_sel    (sram_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-round responder delays (extra WAIT cycles); -1 withholds the response.
    int kx_dly[16];
    int rnd_dly[16];
    bit spur_en = 1'b0;
    bit quiet   = 1'b0;

    int kx_q[$];
    int rnd_q[$];
    int ini_q[$];
    int fin_q[$];
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each round costs REQ+WAIT for both units plus the extra waits,
    // the first KX_REQ is cycle 1 and DONE follows the last round.
    function automatic int model_latency();
        int t = 1;
        for (int r = 0; r <= NR; r++) t += 4 + kx_dly[r] + rnd_dly[r];
        return t;
    endfunction

    always @(negedge clk) begin
        if (kx_enable === 1'b1) kx_q.push_back(int'(kx_round));
        if (rnd_start === 1'b1) begin
            rnd_q.push_back(int'(rnd_num));
            ini_q.push_back(int'(rnd_initial));
            fin_q.push_back(int'(rnd_final));
        end
        if (done === 1'b1) done_cnt++;
    end

    always begin : kx_responder
        int d;
        logic [3:0] held;
        @(negedge clk);
        if (kx_enable === 1'b1 && !rst) begin
            held = kx_round;
            d = kx_dly[held - 4'd1];
            if (d >= 0) begin
                @(posedge clk); #1;
                repeat (d) begin
                    rnd_done_spur = spur_en;
                    if (!quiet) check("kx_wait_owner", {sram_sel, busy, kx_round}, {1'b0, 1'b1, held});
                    @(posedge clk); #1;
                end
                rnd_done_spur = 1'b0;
                kx_done_resp  = 1'b1;
                if (!quiet) check("kx_wait_owner", {sram_sel, busy, kx_round}, {1'b0, 1'b1, held});
                @(posedge clk); #1;
                kx_done_resp = 1'b0;
            end
        end
    end

    always begin : rnd_responder
        int d;
        logic [3:0] held;
        @(negedge clk);
        if (rnd_start === 1'b1 && !rst) begin
            held = rnd_num;
            d = rnd_dly[held];
            if (d >= 0) begin
                @(posedge clk); #1;
                repeat (d) begin
                    kx_done_spur = spur_en;
                    if (!quiet) check("rnd_wait_owner", {sram_sel, rnd_num}, {1'b1, held});
                    @(posedge clk); #1;
                end
                kx_done_spur  = 1'b0;
                rnd_done_resp = 1'b1;
                if (!quiet) check("rnd_wait_owner", {sram_sel, rnd_num}, {1'b1, held});
                @(posedge clk); #1;
                rnd_done_resp = 1'b0;
            end
        end
    end

    task automatic wait_for(input string tag, input bit want_error, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((want_error ? error : done) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(tag, want_error ? error : done, 1'b1);
    endtask

    task automatic clear_queues();
        kx_q.delete();
        rnd_q.delete();
        ini_q.delete();
        fin_q.delete();
    endtask

    task automatic check_sequences(input string tag);
        check({tag, "_kx_count"}, kx_q.size(), NR + 1);
        check({tag, "_rnd_count"}, rnd_q.size(), NR + 1);
        for (int i = 0; i < kx_q.size() && i <= NR; i++)
            check({tag, "_kx_round"}, kx_q[i], i + 1);
        for (int i = 0; i < rnd_q.size() && i <= NR; i++) begin
            check({tag, "_rnd_num"}, rnd_q[i], i);
            check({tag, "_rnd_initial"}, ini_q[i], (i == 0) ? 1 : 0);
            check({tag, "_rnd_final"}, fin_q[i], (i == NR) ? 1 : 0);
        end
    endtask

    task automatic run_block(input string tag);
        int c0, at, exp_lat;
        clear_queues();
        exp_lat = model_latency();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check({tag, "_first_req"}, {busy, error, kx_enable, kx_round}, {1'b1, 1'b0, 1'b1, 4'd1});
        start = 1'b0;
        wait_for({tag, "_done_seen"}, 1'b0, 600, at);
        check({tag, "_latency"}, at - c0, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, busy, sram_sel}, 3'b000);
        check_sequences(tag);
    endtask

    task automatic zero_delays();
        for (int i = 0; i < 16; i++) begin
            kx_dly[i]  = 0;
            rnd_dly[i] = 0;
        end
    endtask

    initial begin : watchdog_guard
        #400000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int c0, c1, at, dc;
        zero_delays();

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", outs, 16'h0000);

        run_block("zero_dly");
        check("zero_dly_model", model_latency(), 45);

        for (int i = 0; i <= NR; i++) kx_dly[i] = 5;
        run_block("kx_dly5");
        check("kx_dly5_model", model_latency(), 100);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i <= NR; i++) begin
                kx_dly[i]  = $urandom_range(0, 4);
                rnd_dly[i] = $urandom_range(0, 4);
            end
            run_block("random");
        end

        spur_en = 1'b1;
        for (int i = 0; i <= NR; i++) begin
            kx_dly[i]  = $urandom_range(1, 3);
            rnd_dly[i] = $urandom_range(1, 3);
        end
        run_block("spurious");
        spur_en = 1'b0;

        // start held high across a whole block
        zero_delays();
        clear_queues();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        dc = done_cnt;
        wait_for("hold_done_seen", 1'b0, 200, at);
        check("hold_latency", at - c0, model_latency());
        @(negedge clk);
        check("hold_idle_gap", {busy, done, kx_enable}, 3'b000);
        check("hold_one_done", done_cnt - dc, 1);
        check_sequences("hold");
        @(negedge clk);
        check("hold_restart", {busy, kx_enable, kx_round}, {1'b1, 1'b1, 4'd1});
        start = 1'b0;
        c1 = cyc - 1;
        wait_for("hold2_done_seen", 1'b0, 200, at);
        check("hold2_latency", at - c1, model_latency());
        @(negedge clk);

        // asynchronous reset in RND_WAIT of round 4
        rnd_dly[4] = 5;
        quiet = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rnd_start === 1'b1 && rnd_num === 4'd4) begin
                at = cyc;
                break;
            end
        end
        check("rst_found_round4", {rnd_start, rnd_num}, {1'b1, 4'd4});
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", outs, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_stays_idle", outs, 16'h0000);
        quiet = 1'b0;
        rnd_dly[4] = 0;
        run_block("after_rst");

`ifdef AES_SCHED_TIMEOUT_EN
        zero_delays();
        kx_dly[2] = -1;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_for("timeout_error_seen", 1'b1, 100, at);
        check("timeout_cycle", at - c0, 1 + 2 * 4 + 1 + TO);
        check("timeout_err_outs", {error, busy, sram_sel, done}, 4'b1000);
        @(negedge clk);
        check("timeout_err_held", {error, busy}, 2'b10);
        kx_dly[2] = 0;
        run_block("after_err");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
